// File: rtl/cc_job_ctrl.sv
// cc_job_ctrl: serial job front-end for the combinational Code Calculator datapath.
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     operand beat valid
//   in_ready_o     controller can accept a beat (IDLE/LOAD only)
//   in_data_i      operand nibble; beats 0..3 go to cc_in_n0..3
//   in_opt_i       opcode, taken on beat 0 only
//   cc_in_n*_o     registered operands to the CC
//   cc_opt_o       registered opcode to the CC
//   cc_out_n_i     CC result
//   out_valid_o    captured result valid
//   out_ready_i    downstream accepts the result
//   out_data_o     captured result
//   out_tag_o      index of the presented job
module cc_job_ctrl #(
    parameter int CC_WAIT = 1,
    parameter int TAG_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_data_i,
    input  logic [2:0]       in_opt_i,
    output logic [3:0]       cc_in_n0_o,
    output logic [3:0]       cc_in_n1_o,
    output logic [3:0]       cc_in_n2_o,
    output logic [3:0]       cc_in_n3_o,
    output logic [2:0]       cc_opt_o,
    input  logic [8:0]       cc_out_n_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [8:0]       out_data_o,
    output logic [TAG_W-1:0] out_tag_o
);
    typedef enum logic [1:0] {IDLE, LOAD, EXEC, HOLD} state_e;

    localparam logic [3:0] WAIT_LAST = 4'(CC_WAIT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [3:0]        wait_q, wait_d;
    logic [3:0][3:0]   n_q, n_d;
    logic [2:0]        opt_q, opt_d;
    logic [8:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              accept;

    assign in_ready_o  = (state_q == IDLE) || (state_q == LOAD);
    assign accept      = in_valid_i && in_ready_o;
    assign cc_in_n0_o  = n_q[0];
    assign cc_in_n1_o  = n_q[1];
    assign cc_in_n2_o  = n_q[2];
    assign cc_in_n3_o  = n_q[3];
    assign cc_opt_o    = opt_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_tag_o   = tag_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            n_q     <= '0;
            opt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            n_q     <= n_d;
            opt_q   <= opt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        n_d     = n_q;
        opt_d   = opt_q;
        data_d  = data_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: if (accept) begin
                n_d[0]  = in_data_i;
                opt_d   = in_opt_i;
                cnt_d   = 2'd1;
                state_d = LOAD;
            end
            LOAD: if (accept) begin
                n_d[cnt_q] = in_data_i;
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    wait_d  = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // wait_q counts settle cycles since the last operand landed
                wait_d = wait_q + 4'd1;
                if (wait_q == WAIT_LAST) begin
                    data_d  = cc_out_n_i;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: if (out_ready_i) begin
                valid_d = 1'b0;
                tag_d   = tag_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cc_job_ctrl.sv
// tb_cc_job_ctrl: directed bench; instance 0 uses CC_WAIT=1, instance 1 uses CC_WAIT=3.
module tb_cc_job_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic [2:0] in_opt = '0;
    logic       out_ready = 1'b0;
    logic [8:0] cc_out_n = '0;
    bit         sel = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    logic       rdy [2];
    logic [3:0] n0 [2];
    logic [3:0] n1 [2];
    logic [3:0] n2 [2];
    logic [3:0] n3 [2];
    logic [2:0] opt [2];
    logic       vld [2];
    logic [8:0] dat [2];
    logic [7:0] tag [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cc_job_ctrl #(.CC_WAIT(1), .TAG_W(8)) u_w1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid && !sel), .in_ready_o(rdy[0]),
        .in_data_i(in_data), .in_opt_i(in_opt),
        .cc_in_n0_o(n0[0]), .cc_in_n1_o(n1[0]), .cc_in_n2_o(n2[0]), .cc_in_n3_o(n3[0]),
        .cc_opt_o(opt[0]), .cc_out_n_i(cc_out_n), .out_valid_o(vld[0]),
        .out_ready_i(out_ready), .out_data_o(dat[0]), .out_tag_o(tag[0])
    );

    cc_job_ctrl #(.CC_WAIT(3), .TAG_W(8)) u_w3 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid && sel), .in_ready_o(rdy[1]),
        .in_data_i(in_data), .in_opt_i(in_opt),
        .cc_in_n0_o(n0[1]), .cc_in_n1_o(n1[1]), .cc_in_n2_o(n2[1]), .cc_in_n3_o(n3[1]),
        .cc_opt_o(opt[1]), .cc_out_n_i(cc_out_n), .out_valid_o(vld[1]),
        .out_ready_i(out_ready), .out_data_o(dat[1]), .out_tag_o(tag[1])
    );

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", t, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] d, input logic [2:0] o);
        in_valid = 1'b1;
        in_data  = d;
        in_opt   = o;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!vld[sel] && n < 20) begin
            step();
            n++;
        end
        check("valid_timeout", 32'(vld[sel]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        // reset then idle
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            check("rst_ready", 32'(rdy[sel]), 1);
            check("rst_valid", 32'(vld[sel]), 0);
            check("rst_cc", {n0[sel], n1[sel], n2[sel], n3[sel], 1'b0, opt[sel]}, 0);
            check("rst_tag", 32'(tag[sel]), 0);
        end
        rst_n = 1'b1;
        step();

        // basic job, CC_WAIT=1
        sel = 1'b0;
        out_ready = 1'b1;
        cc_out_n = 9'h1A5;
        beat(4'hA, 3'd5);
        check("b_n0", 32'(n0[0]), 4'hA);
        check("b_opt0", 32'(opt[0]), 5);
        beat(4'h3, 3'd2);
        beat(4'hF, 3'd2);
        beat(4'h0, 3'd2);
        check("b_cc", {n0[0], n1[0], n2[0], n3[0]}, 16'hA3F0);
        check("b_opt", 32'(opt[0]), 5);
        check("b_valid_k", 32'(vld[0]), 0);
        check("b_ready_exec", 32'(rdy[0]), 0);
        step();
        check("b_valid_k1", 32'(vld[0]), 1);
        check("b_data", 32'(dat[0]), 9'h1A5);
        check("b_tag", 32'(tag[0]), 0);
        step();
        check("b_valid_k2", 32'(vld[0]), 0);
        check("b_tag_inc", 32'(tag[0]), 1);
        check("b_ready_idle", 32'(rdy[0]), 1);

        // gapped input with back-pressure, CC_WAIT=3
        sel = 1'b1;
        out_ready = 1'b0;
        cc_out_n = 9'h0C3;
        beat(4'h5, 3'd3);
        check("g_n0", 32'(n0[1]), 5);
        check("g_opt", 32'(opt[1]), 3);
        beat(4'h6, 3'd1);
        check("g_n1", 32'(n1[1]), 6);
        in_data = 4'hF;
        repeat (2) begin
            step();
            check("g_gap_n2", 32'(n2[1]), 0);
            check("g_gap_ready", 32'(rdy[1]), 1);
        end
        beat(4'h7, 3'd1);
        check("g_n2", 32'(n2[1]), 7);
        beat(4'h8, 3'd1);
        check("g_cc", {n0[1], n1[1], n2[1], n3[1], 1'b0, opt[1]}, 20'h56783);
        check("g_ready_k", 32'(rdy[1]), 0);
        check("g_valid_k", 32'(vld[1]), 0);
        in_valid = 1'b1;
        in_data = 4'hE;
        repeat (2) begin
            step();
            check("g_valid_exec", 32'(vld[1]), 0);
            check("g_ready_exec", 32'(rdy[1]), 0);
        end
        step();
        check("g_valid_k3", 32'(vld[1]), 1);
        check("g_data", 32'(dat[1]), 9'h0C3);
        check("g_tag", 32'(tag[1]), 0);
        cc_out_n = 9'h111;
        for (int i = 0; i < 5; i++) begin
            check("g_hold_valid", 32'(vld[1]), 1);
            check("g_hold_data", 32'(dat[1]), 9'h0C3);
            check("g_hold_ready", 32'(rdy[1]), 0);
            check("g_hold_n3", 32'(n3[1]), 8);
            step();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        check("g_valid_last", 32'(vld[1]), 1);
        step();
        check("g_valid_done", 32'(vld[1]), 0);
        check("g_tag_inc", 32'(tag[1]), 1);

        // reset in LOAD after 2 beats
        sel = 1'b0;
        beat(4'h1, 3'd1);
        beat(4'h2, 3'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rl_n0", 32'(n0[0]), 0);
        check("rl_n1", 32'(n1[0]), 0);
        check("rl_tag", 32'(tag[0]), 0);
        check("rl_ready", 32'(rdy[0]), 1);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            check("rl_no_valid", 32'(vld[0]), 0);
        end

        // job to HOLD, then reset in HOLD
        out_ready = 1'b0;
        cc_out_n = 9'h155;
        beat(4'h9, 3'd4);
        beat(4'h8, 3'd0);
        beat(4'h7, 3'd0);
        beat(4'h6, 3'd0);
        wait_valid();
        check("rh_tag", 32'(tag[0]), 0);
        check("rh_data", 32'(dat[0]), 9'h155);
        check("rh_cc", {n0[0], n1[0], n2[0], n3[0], 1'b0, opt[0]}, 20'h98764);
        #2 rst_n = 1'b0;
        #1;
        check("rh_valid", 32'(vld[0]), 0);
        check("rh_data_clr", 32'(dat[0]), 0);
        check("rh_n3", 32'(n3[0]), 0);
        check("rh_ready", 32'(rdy[0]), 1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        beat(4'h4, 3'd6);
        beat(4'h4, 3'd0);
        beat(4'h4, 3'd0);
        beat(4'h4, 3'd0);
        wait_valid();
        check("rh_next_tag", 32'(tag[0]), 0);
        step();
        check("rh_next_done", 32'(vld[0]), 0);

        // tag wrap with back-to-back jobs
        rst_n = 1'b0;
        step();
        cc_out_n = 9'h0AA;
        in_data = 4'h3;
        in_valid = 1'b1;
        rst_n = 1'b1;
        last = 0;
        for (int j = 0; j < 257; j++) begin
            wait_valid();
            check("w_tag", 32'(tag[0]), j & 255);
            if (j > 0) check("w_period", cyc - last, 6);
            last = cyc;
            step();
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
